pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter STALL_LIMIT, default 8'd255: number of consecutive stall cycles that raises stall_timeout.
REQ-002 clk  input  1  pipeline clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high (`RstEnable = 1'b1).
REQ-004 stallreq_id  input  1  decode requests a hold (load-use hazard).
REQ-005 stallreq_ex  input  1  execute requests a hold (multi-cycle operation).
REQ-006 stallreq_mem  input  1  memory stage requests a hold (bus wait).
REQ-007 excp_req  input  1  exception raised; pipeline must be flushed.
REQ-008 excp_vec  input  32  handler target PC, valid with excp_req.
REQ-009 eret_req  input  1  return-from-exception request.
REQ-010 epc  input  32  return target PC, valid with eret_req.
REQ-011 stall  output  6  hold vector: bit0 pc, bit1 if_id, bit2 id_ex, bit3 ex_mem, bit4 mem_wb, bit5 wb.
REQ-012 flush  output  1  clears all pipeline registers (if_id through mem_wb).
REQ-013 new_pc  output  32  redirect target, valid while flush=1.
REQ-014 stall_timeout  output  1  sticky watchdog flag.
REQ-015 stall_cycles  output  32  total count of cycles with stall[0]=1.

Function
REQ-016 The FSM SHALL have three states: RUN, FLUSH, DRAIN.
REQ-017 In RUN, stall SHALL be combinational from requests with priority mem > ex > id: mem -> 6'b011111; ex -> 6'b001111; id -> 6'b000111; none -> 6'b000000.
REQ-018 In RUN, excp_req=1 SHALL latch excp_vec and move to FLUSH; otherwise eret_req=1 SHALL latch epc and move to FLUSH.
REQ-019 When excp_req and eret_req are both 1, excp_req SHALL win and epc SHALL be ignored.
REQ-020 Stall requests asserted in the request cycle SHALL still drive stall in that cycle; redirection latency is exactly one cycle.
REQ-021 In FLUSH (one cycle), flush=1, new_pc=latched target, stall=6'b000000; excp_req and eret_req SHALL be ignored; next state DRAIN.
REQ-022 In DRAIN (one cycle), flush=0, stall=6'b000000; stall requests SHALL be ignored as stale; excp_req/eret_req SHALL be honoured as in RUN; otherwise next state RUN.
REQ-023 Outside FLUSH, flush SHALL be 0 and new_pc SHALL be 32'h0.
REQ-024 An exception arriving while a stall is active SHALL be accepted; stall drops to 0 in the following FLUSH cycle.
REQ-025 An 8-bit run counter SHALL increment on every cycle with stall[0]=1, saturating at 8'hFF, and clear to 0 on any cycle with stall[0]=0.
REQ-026 When the run counter increments into STALL_LIMIT, stall_timeout SHALL set on that edge and remain 1 until a FLUSH cycle or reset.
REQ-027 stall_cycles SHALL increment by 1 on every cycle with stall[0]=1, wrapping from 32'hFFFFFFFF to 0.

Reset
REQ-028 On rst=1, independent of clk: state RUN, latched target 32'h0, run counter 0, stall_timeout 0, stall_cycles 0.
REQ-029 During reset, stall SHALL be 6'b000000, flush SHALL be 0, and new_pc SHALL be 32'h0, even if requests are asserted.
REQ-030 Reset asserted mid-FLUSH or mid-DRAIN SHALL abort the redirect; the first cycle after release is RUN with no flush.

Structure
REQ-031 Stall vector encodings, FSM state codes (2-bit), and `RstEnable/`ZeroWord SHALL live in defines.v, included by this block and by the pipeline registers.
REQ-032 The run counter and the stall_timeout flag SHALL be one sub-module, pipe_stall_wdog (inputs clk, rst, stall0, clr; output timeout).
REQ-033 Pipeline registers SHALL consume stall/flush; this block SHALL NOT contain datapath registers.

Verification
REQ-034 Reset release with no requests -> stall=0, flush=0, stall_cycles=0 over 10 cycles.
REQ-035 stallreq_id and stallreq_mem both 1 for 3 cycles -> stall=6'b011111 for those 3 cycles; stall_cycles=3.
REQ-036 excp_req=1 with excp_vec=32'hBFC00380 in cycle N while stallreq_ex=1 -> stall=6'b001111 in N; flush=1 and new_pc=32'hBFC00380 in N+1; stall=0 in N+2 although stallreq_ex is still 1; RUN in N+3.
REQ-037 excp_req and eret_req both 1 (epc=32'h80000010, excp_vec=32'hBFC00380) -> new_pc=32'hBFC00380.
REQ-038 STALL_LIMIT=4 with stallreq_mem held -> stall_timeout rises on the 4th stalled edge and stays 1; a later excp_req clears it in the FLUSH cycle.
REQ-039 rst asserted during FLUSH -> flush=0 immediately (no clock edge); after release, no redirect occurs.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared encodings for the pipeline controller and the stage
//               registers that consume its stall/flush outputs.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    localparam logic        c_rst_enable = 1'b1;
    localparam logic [31:0] c_zero_word  = 32'h0000_0000;

    // Hold vector bit order: pc, if_id, id_ex, ex_mem, mem_wb, wb
    localparam logic [5:0] c_stall_none = 6'b000000;
    localparam logic [5:0] c_stall_id   = 6'b000111;
    localparam logic [5:0] c_stall_ex   = 6'b001111;
    localparam logic [5:0] c_stall_mem  = 6'b011111;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // The deepest requesting stage freezes itself and everything upstream.
    function automatic logic [5:0] stall_encode(input logic id, input logic ex,
                                                input logic mem);
        logic [5:0] v;
        v = c_stall_none;
        if (mem)
            v = c_stall_mem;
        else if (ex)
            v = c_stall_ex;
        else if (id)
            v = c_stall_id;
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_stall_wdog.sv
// ============================================================================
// Module      : pipe_stall_wdog
// Description : Consecutive-stall run counter with a sticky timeout flag.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pipe_stall_wdog
    import pipe_ctrl_pkg::*;
#(
    parameter logic [7:0] STALL_LIMIT = 8'd255
) (
    input  logic clk,
    input  logic rst,
    input  logic stall0,
    input  logic clr,
    output logic timeout
);

    logic [7:0] r_run_cnt;
    logic       r_timeout;
    logic       w_inc;
    logic [7:0] w_cnt_next;

    assign w_inc      = stall0 && (r_run_cnt != 8'hFF);
    assign w_cnt_next = r_run_cnt + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst == c_rst_enable) begin
            r_run_cnt <= 8'd0;
            r_timeout <= 1'b0;
        end else begin
            if (!stall0)
                r_run_cnt <= 8'd0;
            else if (w_inc)
                r_run_cnt <= w_cnt_next;

            // Flag sets only on the edge where the count steps into the limit.
            if (clr)
                r_timeout <= 1'b0;
            else if (w_inc && (w_cnt_next == STALL_LIMIT))
                r_timeout <= 1'b1;
        end
    end

    assign timeout = r_timeout;

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// Module      : pipe_ctrl
// Description : Pipeline hazard/redirect controller: stall vector, flush and
//               redirect PC sequencing, stall watchdog and stall statistics.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [7:0] STALL_LIMIT = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        excp_req,
    input  logic [31:0] excp_vec,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        stall_timeout,
    output logic [31:0] stall_cycles
);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_target;
    logic [31:0] w_target;
    logic        w_load;
    logic [5:0]  w_stall;
    logic        w_flush;
    logic [31:0] w_new_pc;
    logic [31:0] r_stall_cycles;
    logic        w_in_rst;

    assign w_in_rst = (rst == c_rst_enable);

    always_ff @(posedge clk or posedge rst) begin
        if (rst == c_rst_enable) begin
            r_state        <= ST_RUN;
            r_target       <= c_zero_word;
            r_stall_cycles <= c_zero_word;
        end else begin
            r_state <= w_next;
            if (w_load)
                r_target <= w_target;
            if (w_stall[0])
                r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_target = c_zero_word;
        w_stall  = c_stall_none;
        w_flush  = 1'b0;
        w_new_pc = c_zero_word;

        case (r_state)
            ST_RUN:   w_stall = stall_encode(stallreq_id, stallreq_ex, stallreq_mem);
            ST_FLUSH: begin
                w_flush  = 1'b1;
                w_new_pc = r_target;
                w_next   = ST_DRAIN;
            end
            ST_DRAIN: w_next = ST_RUN;
            default:  w_next = ST_RUN;
        endcase

        // Redirects are accepted in RUN and DRAIN; exceptions beat eret.
        if (r_state != ST_FLUSH) begin
            if (excp_req) begin
                w_load   = 1'b1;
                w_target = excp_vec;
                w_next   = ST_FLUSH;
            end else if (eret_req) begin
                w_load   = 1'b1;
                w_target = epc;
                w_next   = ST_FLUSH;
            end
        end
    end

    // Outputs are forced quiet while reset is held, regardless of requests.
    assign stall        = w_in_rst ? c_stall_none : w_stall;
    assign flush        = w_in_rst ? 1'b0 : w_flush;
    assign new_pc       = w_in_rst ? c_zero_word : w_new_pc;
    assign stall_cycles = r_stall_cycles;

    pipe_stall_wdog #(
        .STALL_LIMIT (STALL_LIMIT)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .stall0  (stall[0]),
        .clr     (flush),
        .timeout (stall_timeout)
    );

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// Module      : tb_pipe_ctrl
// Description : Scoreboard bench for pipe_ctrl driven by directed vectors.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_id;
    logic        stallreq_ex;
    logic        stallreq_mem;
    logic        excp_req;
    logic [31:0] excp_vec;
    logic        eret_req;
    logic [31:0] epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout;
    logic [31:0] stall_cycles;

    pipe_ctrl #(
        .STALL_LIMIT (8'd4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stallreq_id   (stallreq_id),
        .stallreq_ex   (stallreq_ex),
        .stallreq_mem  (stallreq_mem),
        .excp_req      (excp_req),
        .excp_vec      (excp_vec),
        .eret_req      (eret_req),
        .epc           (epc),
        .stall         (stall),
        .flush         (flush),
        .new_pc        (new_pc),
        .stall_timeout (stall_timeout),
        .stall_cycles  (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic        to;
        logic [31:0] cyc;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   vid   = 0;
    event ev_async;

    task automatic chk1(input int id, input string nm, input logic [31:0] got,
                        input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL vec%0d %s: got %h want %h", id, nm, got, want);
        end
    endtask

    // Monitor: checks every pending expectation on the falling edge, or
    // immediately when stimulus signals an asynchronous (reset) check.
    always begin
        @(negedge clk or ev_async);
        while (q.size() > 0) begin
            m_e = q.pop_front();
            chk1(m_e.id, "stall",         {26'd0, stall},         {26'd0, m_e.stall});
            chk1(m_e.id, "flush",         {31'd0, flush},         {31'd0, m_e.flush});
            chk1(m_e.id, "new_pc",        new_pc,                 m_e.pc);
            chk1(m_e.id, "stall_timeout", {31'd0, stall_timeout}, {31'd0, m_e.to});
            chk1(m_e.id, "stall_cycles",  stall_cycles,           m_e.cyc);
        end
    end

    task automatic expect_now(input logic [5:0] s, input logic f, input logic [31:0] p,
                              input logic t, input logic [31:0] c);
        exp_t e;
        e.id = vid; e.stall = s; e.flush = f; e.pc = p; e.to = t; e.cyc = c;
        q.push_back(e);
        vid++;
    endtask

    // One clock of stimulus plus its hand-computed expected outputs.
    task automatic cyc(input logic id_i, input logic ex_i, input logic mem_i,
                       input logic exc_i, input logic [31:0] vec_i,
                       input logic eret_i, input logic [31:0] epc_i,
                       input logic [5:0] s, input logic f, input logic [31:0] p,
                       input logic t, input logic [31:0] c);
        stallreq_id  = id_i;
        stallreq_ex  = ex_i;
        stallreq_mem = mem_i;
        excp_req     = exc_i;
        excp_vec     = vec_i;
        eret_req     = eret_i;
        epc          = epc_i;
        expect_now(s, f, p, t, c);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        stallreq_id = 1'b0; stallreq_ex = 1'b0; stallreq_mem = 1'b0;
        excp_req = 1'b0; excp_vec = 32'h0; eret_req = 1'b0; epc = 32'h0;

        // Outputs quiet during reset even with every request asserted.
        #12;
        stallreq_id = 1'b1; stallreq_mem = 1'b1; excp_req = 1'b1; eret_req = 1'b1;
        excp_vec = 32'hBFC00380;
        expect_now(6'b000000, 1'b0, 32'h0, 1'b0, 32'd0);
        -> ev_async;
        #1;
        @(posedge clk); #1;
        stallreq_id = 1'b0; stallreq_mem = 1'b0; excp_req = 1'b0; eret_req = 1'b0;
        rst = 1'b0;

        // Idle after reset release.
        repeat (10) cyc(0,0,0, 0,32'h0, 0,32'h0, 6'b000000,0,32'h0,0,32'd0);

        // id + mem for three cycles: mem priority.
        for (int i = 0; i < 3; i++)
            cyc(1,0,1, 0,32'h0, 0,32'h0, 6'b011111,0,32'h0,0,32'(i));
        cyc(0,0,0, 0,32'h0, 0,32'h0, 6'b000000,0,32'h0,0,32'd3);

        // Exception during an ex stall; stale stall ignored in DRAIN.
        cyc(0,1,0, 1,32'hBFC00380, 0,32'h0, 6'b001111,0,32'h0,0,32'd3);
        cyc(0,1,0, 0,32'h0, 0,32'h0, 6'b000000,1,32'hBFC00380,0,32'd4);
        cyc(0,1,0, 0,32'h0, 0,32'h0, 6'b000000,0,32'h0,0,32'd4);
        cyc(0,1,0, 0,32'h0, 0,32'h0, 6'b001111,0,32'h0,0,32'd4);
        cyc(0,0,0, 0,32'h0, 0,32'h0, 6'b000000,0,32'h0,0,32'd5);

        // excp beats eret; FLUSH ignores requests; DRAIN honours eret.
        cyc(0,0,0, 1,32'hBFC00380, 1,32'h80000010, 6'b000000,0,32'h0,0,32'd5);
        cyc(0,0,0, 1,32'h11111111, 0,32'h0, 6'b000000,1,32'hBFC00380,0,32'd5);
        cyc(0,0,0, 0,32'h0, 1,32'h80000010, 6'b000000,0,32'h0,0,32'd5);
        cyc(0,0,0, 0,32'h0, 0,32'h0, 6'b000000,1,32'h80000010,0,32'd5);
        cyc(0,0,1, 0,32'h0, 0,32'h0, 6'b000000,0,32'h0,0,32'd5);
        cyc(0,0,0, 0,32'h0, 0,32'h0, 6'b000000,0,32'h0,0,32'd5);

        // Watchdog with limit 4: sets on the 4th stalled edge, cleared by FLUSH.
        for (int i = 0; i < 6; i++)
            cyc(0,0,1, 0,32'h0, 0,32'h0, 6'b011111,0,32'h0,logic'(i >= 4),32'(5 + i));
        cyc(0,0,1, 1,32'hBFC00380, 0,32'h0, 6'b011111,0,32'h0,1,32'd11);
        cyc(0,0,1, 0,32'h0, 0,32'h0, 6'b000000,1,32'hBFC00380,1,32'd12);
        cyc(0,0,1, 0,32'h0, 0,32'h0, 6'b000000,0,32'h0,0,32'd12);
        cyc(0,0,0, 0,32'h0, 0,32'h0, 6'b000000,0,32'h0,0,32'd12);

        // Reset during FLUSH aborts the redirect without a clock edge.
        cyc(0,0,0, 1,32'hBFC00380, 0,32'h0, 6'b000000,0,32'h0,0,32'd12);
        excp_req = 1'b0;
        expect_now(6'b000000, 1'b1, 32'hBFC00380, 1'b0, 32'd12);
        -> ev_async;
        #1;
        rst = 1'b1;
        #1;
        expect_now(6'b000000, 1'b0, 32'h0, 1'b0, 32'd0);
        -> ev_async;
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(0,0,0, 0,32'h0, 0,32'h0, 6'b000000,0,32'h0,0,32'd0);
        cyc(0,0,0, 0,32'h0, 0,32'h0, 6'b000000,0,32'h0,0,32'd0);

        @(negedge clk); #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
